// File: rtl/bus_demux_fifo.sv
// bus_demux_fifo: routes one valid/ready source stream to two independent
// 2-entry FIFO channels (A when in_sel=0, B when in_sel=1).
// Optional feature: define BUS_DEMUX_FIFO_CNT_EN to add 8-bit per-channel
// output-transfer counters on ports a_cnt / b_cnt.
module bus_demux_fifo #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef BUS_DEMUX_FIFO_CNT_EN
    ,
    output logic [7:0]       a_cnt,
    output logic [7:0]       b_cnt
`endif
);

    localparam int CH_A = 0;
    localparam int CH_B = 1;

    // Per-channel storage and bookkeeping, indexed [channel].
    logic [WIDTH-1:0] r_mem   [2][2];
    logic [1:0]       r_count [2];
    logic             r_wptr  [2];
    logic             r_rptr  [2];

    logic [1:0] w_has_room;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    // Accept decision looks only at the selected channel's registered count,
    // so a same-cycle pop never makes a full channel ready.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        w_has_room = 2'b00;
        w_push     = 2'b00;
        w_pop      = 2'b00;
        in_ready   = 1'b0;

        w_has_room[CH_A] = (r_count[CH_A] < 2'd2);
        w_has_room[CH_B] = (r_count[CH_B] < 2'd2);
        in_ready         = rst_n & (in_sel ? w_has_room[CH_B] : w_has_room[CH_A]);

        w_push[CH_A] = in_valid & in_ready & ~in_sel;
        w_push[CH_B] = in_valid & in_ready &  in_sel;
        w_pop[CH_A]  = a_valid & a_ready;
        w_pop[CH_B]  = b_valid & b_ready;
    end

    // Outputs come straight from registers; no path from the in_* ports.
    assign a_valid = (r_count[CH_A] != 2'd0);
    assign b_valid = (r_count[CH_B] != 2'd0);
    assign a_data  = r_mem[CH_A][r_rptr[CH_A]];
    assign b_data  = r_mem[CH_B][r_rptr[CH_B]];

    // FIFO state per channel: write on push, advance read on pop, track count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                // NOTE: the storage is reset as well so head data reads 0 during reset.
                r_mem[ch][0] <= '0;
                r_mem[ch][1] <= '0;
                r_count[ch]  <= 2'd0;
                r_wptr[ch]   <= 1'b0;
                r_rptr[ch]   <= 1'b0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                // NOTE: non-blocking assignments keep every register update on the same edge.
                if (w_push[ch]) begin
                    r_mem[ch][r_wptr[ch]] <= in_data;
                    r_wptr[ch]            <= ~r_wptr[ch];
                end
                if (w_pop[ch]) begin
                    r_rptr[ch] <= ~r_rptr[ch];
                end
                case ({w_push[ch], w_pop[ch]})
                    2'b10:   r_count[ch] <= r_count[ch] + 2'd1;
                    2'b01:   r_count[ch] <= r_count[ch] - 2'd1;
                    default: r_count[ch] <= r_count[ch];
                endcase
            end
        end
    end

`ifdef BUS_DEMUX_FIFO_CNT_EN
    logic [7:0] r_a_cnt;
    logic [7:0] r_b_cnt;

    // Output-transfer counters, wrapping naturally at 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_cnt <= 8'd0;
            r_b_cnt <= 8'd0;
        end else begin
            if (w_pop[CH_A]) r_a_cnt <= r_a_cnt + 8'd1;
            if (w_pop[CH_B]) r_b_cnt <= r_b_cnt + 8'd1;
        end
    end

    assign a_cnt = r_a_cnt;
    assign b_cnt = r_b_cnt;
`endif

endmodule

// File: tb/tb_bus_demux_fifo.sv
// Testbench for bus_demux_fifo: directed scenarios plus a randomized run
// against a queue-based reference model of the two channels.
module tb_bus_demux_fifo;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
`ifdef BUS_DEMUX_FIFO_CNT_EN
    logic [7:0]       a_cnt;
    logic [7:0]       b_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bus_demux_fifo #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef BUS_DEMUX_FIFO_CNT_EN
        ,
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({a_valid, b_valid, a_data, b_data, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: a_valid=%b b_valid=%b a_data=%h b_data=%h in_ready=%b, expected all 0",
                     a_valid, b_valid, a_data, b_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int s = 0; s < 2; s++) begin
            in_sel = s[0];
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release_ready sel=%0d: got %b, expected 1", s, in_ready);
            end
        end
    endtask

    task automatic test_routing();
        apply_reset();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5;
        step();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (a_valid !== 1'b1 || a_data !== 4'h5 || b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL routing: a_valid=%b a_data=%h b_valid=%b, expected 1 5 0", a_valid, a_data, b_valid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
        step();
        in_data = 4'h2;
        step();
        in_valid = 1'b0; in_sel = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_a_ready_sel0: got %b, expected 0", in_ready);
        end
        in_sel = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_a_ready_sel1: got %b, expected 1", in_ready);
        end
        in_valid = 1'b1; in_data = 4'h3;
        step();
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (b_valid !== 1'b1 || b_data !== 4'h3) begin
            n_fail++;
            $display("FAIL push_b_while_a_full: b_valid=%b b_data=%h, expected 1 3", b_valid, b_data);
        end
        n_tests++;
        if (a_data !== 4'h1) begin
            n_fail++;
            $display("FAIL a_hold_stable: got %h, expected 1", a_data);
        end
        // Draining a full channel must not make it ready in the same cycle.
        in_sel = 1'b0; a_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_draining_ready: got %b, expected 0", in_ready);
        end
        step();
        n_tests++;
        if (a_valid !== 1'b1 || a_data !== 4'h2) begin
            n_fail++;
            $display("FAIL a_second_word: a_valid=%b a_data=%h, expected 1 2", a_valid, a_data);
        end
        step();
        a_ready = 1'b0;
        #1;
        n_tests++;
        if (a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a_empty_after_drain: got %b, expected 0", a_valid);
        end
        // Ready on an empty channel must not underflow it.
        a_ready = 1'b1;
        step();
        step();
        a_ready = 1'b0;
        in_sel = 1'b0;
        #1;
        n_tests++;
        if (a_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL no_underflow: a_valid=%b in_ready=%b, expected 0 1", a_valid, in_ready);
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h7;
        step();
        in_data = 4'h8; a_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || a_data !== 4'h7) begin
            n_fail++;
            $display("FAIL push_pop_pre: in_ready=%b a_data=%h, expected 1 7", in_ready, a_data);
        end
        step();
        in_valid = 1'b0; a_ready = 1'b0;
        #1;
        n_tests++;
        if (a_valid !== 1'b1 || a_data !== 4'h8) begin
            n_fail++;
            $display("FAIL push_pop_post: a_valid=%b a_data=%h, expected 1 8", a_valid, a_data);
        end
        step();
        n_tests++;
        if (a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL push_pop_count: a_valid=%b, expected 1 (count stays 1)", a_valid);
        end
    endtask

    task automatic test_pointer_wrap();
        logic [WIDTH-1:0] got[$];
        apply_reset();
        b_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_sel   = 1'b1;
            in_valid = (cyc < 6);
            in_data  = cyc[WIDTH-1:0];
            #1;
            if (b_valid) got.push_back(b_data);
            step();
        end
        idle_inputs();
        n_tests++;
        if (got.size() != 6) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d words, expected 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_tests++;
            if (got[i] !== i[WIDTH-1:0]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %h, expected %h", i, got[i], i[WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h9;
        step();
        in_data = 4'hA;
        step();
        in_sel = 1'b1; in_data = 4'hB;
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || in_ready !== 1'b0 || a_data !== '0 || b_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: a_valid=%b b_valid=%b in_ready=%b a_data=%h b_data=%h, expected 0",
                     a_valid, b_valid, in_ready, a_data, b_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int s = 0; s < 2; s++) begin
            in_sel = s[0];
            #1;
            n_tests++;
            if (in_ready !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_release sel=%0d: in_ready=%b a_valid=%b b_valid=%b, expected 1 0 0",
                         s, in_ready, a_valid, b_valid);
            end
        end
`ifdef BUS_DEMUX_FIFO_CNT_EN
        n_tests++;
        if (a_cnt !== 8'd0 || b_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_cnt: a_cnt=%0d b_cnt=%0d, expected 0 0", a_cnt, b_cnt);
        end
`endif
    endtask

`ifdef BUS_DEMUX_FIFO_CNT_EN
    task automatic test_counter_wrap();
        int pops = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400 && pops < 257; cyc++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = cyc[WIDTH-1:0]; a_ready = 1'b1;
            #1;
            if (a_valid) pops++;
            step();
        end
        idle_inputs();
        #1;
        n_tests++;
        if (pops != 257) begin
            n_fail++;
            $display("FAIL cnt_wrap_budget: got %0d transfers, expected 257", pops);
        end
        n_tests++;
        if (a_cnt !== 8'd1 || b_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL cnt_wrap: a_cnt=%0d b_cnt=%0d, expected 1 0", a_cnt, b_cnt);
        end
    endtask
`endif

    // Randomized traffic checked against two bounded queues.
    task automatic test_random();
        logic [WIDTH-1:0] qa[$];
        logic [WIDTH-1:0] qb[$];
        int cnt_a = 0;
        int cnt_b = 0;
        logic push, pop_a, pop_b, exp_ready;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_tests++;
            if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_data !== qa[0])) begin
                n_fail++;
                $display("FAIL rand_a cyc=%0d: a_valid=%b a_data=%h, expected %b %h",
                         cyc, a_valid, a_data, qa.size() != 0, (qa.size() != 0) ? qa[0] : '0);
            end
            n_tests++;
            if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_data !== qb[0])) begin
                n_fail++;
                $display("FAIL rand_b cyc=%0d: b_valid=%b b_data=%h, expected %b %h",
                         cyc, b_valid, b_data, qb.size() != 0, (qb.size() != 0) ? qb[0] : '0);
            end
`ifdef BUS_DEMUX_FIFO_CNT_EN
            n_tests++;
            if (a_cnt !== cnt_a[7:0] || b_cnt !== cnt_b[7:0]) begin
                n_fail++;
                $display("FAIL rand_cnt cyc=%0d: a_cnt=%0d b_cnt=%0d, expected %0d %0d",
                         cyc, a_cnt, b_cnt, cnt_a % 256, cnt_b % 256);
            end
`endif
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = $urandom_range(0, 1) != 0;
            in_data  = WIDTH'($urandom_range(0, 15));
            a_ready  = ($urandom_range(0, 2) == 0);
            b_ready  = ($urandom_range(0, 1) == 0);
            #1;
            exp_ready = in_sel ? (qb.size() < 2) : (qa.size() < 2);
            n_tests++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_in_ready cyc=%0d: got %b, expected %b", cyc, in_ready, exp_ready);
            end
            push  = in_valid && exp_ready;
            pop_a = a_ready && qa.size() != 0;
            pop_b = b_ready && qb.size() != 0;
            step();
            if (pop_a) begin void'(qa.pop_front()); cnt_a++; end
            if (pop_b) begin void'(qb.pop_front()); cnt_b++; end
            if (push) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        test_reset();
        test_routing();
        test_backpressure();
        test_push_pop();
        test_pointer_wrap();
        test_reset_mid();
`ifdef BUS_DEMUX_FIFO_CNT_EN
        test_counter_wrap();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_demux_fifo.md
BUS_DEMUX_FIFO -- requirements
Module: bus_demux_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data bus width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: the source data word.
REQ-005 SHALL have port in_sel, input, 1 bit: destination select (0 = channel A, 1 = channel B).
REQ-006 SHALL have port in_valid, input, 1 bit: the source offers in_data/in_sel.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-008 SHALL have port a_data, output, WIDTH bits: channel A head word.
REQ-009 SHALL have port a_valid, output, 1 bit: channel A holds at least one word.
REQ-010 SHALL have port a_ready, input, 1 bit: the channel A sink takes the head word.
REQ-011 SHALL have ports b_data, b_valid and b_ready, with the same widths and meanings as the channel A ports, for channel B.

Function
REQ-012 SHALL define an input transfer as in_valid=1 and in_ready=1 at a rising clk edge; the word goes to channel A if in_sel=0, else channel B.
REQ-013 SHALL define an output transfer on channel X as X_valid=1 and X_ready=1 at a rising edge; it removes X's head word.
REQ-014 SHALL give each channel an independent 2-entry FIFO: occupancy count 0..2, 1-bit write pointer, 1-bit read pointer, both wrapping 1->0.
REQ-015 SHALL drive in_ready combinationally as 1 when the selected channel's count is less than 2, and 0 otherwise; this holds irrespective of in_valid.
REQ-016 SHALL NOT let in_ready depend on a same-cycle pop; a full channel stays not-ready even while draining.
REQ-017 SHALL drive X_valid = (count_X != 0) and X_data = the entry at the read pointer; both are register-derived, with no combinational path from in_* ports.
REQ-018 SHALL have a latency of one cycle from input transfer to X_valid=1 into an empty channel.
REQ-019 SHALL preserve word order within each channel; the two channels impose no ordering on each other.
REQ-020 SHALL, on a simultaneous push and pop on the same channel with count 1, leave count at 1, advance both pointers and present the new word next cycle.
REQ-021 SHALL ignore X_ready when X_valid=0; the count never underflows.
REQ-022 SHALL let a full channel not block the other channel: with A full and in_sel=1, in_ready follows B's count.
REQ-023 SHALL hold X_data stable while X_valid=1 and X_ready=0.

Reset
REQ-024 SHALL, while rst_n=0, immediately force both counts and pointers to 0 and drive a_valid=b_valid=0, a_data=b_data=0 and in_ready=0.
REQ-025 SHALL, on assertion mid-operation, discard all stored words without emitting any partial output.
REQ-026 SHALL, from the first rising edge after rst_n deasserts, drive in_ready=1 for both in_sel values.

Configuration
REQ-027 SHALL, with macro BUS_DEMUX_FIFO_CNT_EN defined, add output ports a_cnt and b_cnt (8 bits each): per-channel output-transfer counters that increment by 1 per transfer, wrap 255->0, and reset to 0.
REQ-028 SHALL, with BUS_DEMUX_FIFO_CNT_EN undefined, omit the a_cnt/b_cnt ports and counter logic; all other behaviour stays identical.

Verification
REQ-029 SHALL cover basic routing: reset; push 4'h5 with in_sel=0 and a_ready=0 -> next cycle a_valid=1, a_data=4'h5, b_valid=0.
REQ-030 SHALL cover full/backpressure: a_ready=0; push 4'h1 then 4'h2 to A -> in_ready=0 for in_sel=0 and 1 for in_sel=1; push 4'h3 to B is accepted; then with a_ready=1, a_data reads 4'h1 then 4'h2.
REQ-031 SHALL cover simultaneous push/pop: A holds 4'h7; push 4'h8 to A with a_ready=1 -> a_valid stays 1 and a_data is 4'h8 next cycle.
REQ-032 SHALL cover pointer wrap: stream 6 words 4'h0..4'h5 to B with b_ready=1 -> output matches in order, no loss or duplication.
REQ-033 SHALL cover reset mid-operation: A full, B holds 1 word, rst_n pulsed low -> a_valid=b_valid=0 immediately and in_ready=1 after release; with BUS_DEMUX_FIFO_CNT_EN defined, a_cnt=b_cnt=0.
REQ-034 SHALL cover counter wrap (BUS_DEMUX_FIFO_CNT_EN only): 257 A output transfers -> a_cnt=1, b_cnt=0.
